// File: rtl/flatten_seq_pkg.sv
// Shared definitions for the flatten stage: sequencer state encoding,
// default feature-map geometry and the address width helpers.
package flatten_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CAPTURE   = 2'd1,
        S_TRANSPOSE = 2'd2,
        S_READY     = 2'd3
    } flat_state_e;

    localparam int DEF_CHANNELS = 64;
    localparam int DEF_PIXELS   = 16;
    localparam int DEF_POOL_PAR = 8;

    // Element address width into the flatten memories.
    function automatic int flat_aw(input int channels, input int pixels);
        return $clog2(channels * pixels);
    endfunction

    // Pooled-word address width on the capture side.
    function automatic int flat_cw(input int channels, input int pixels, input int pool_par);
        return $clog2((channels * pixels) / pool_par);
    endfunction

endpackage

// File: rtl/flatten_seq_if.sv
// Handshake and BRAM address bus between the flatten sequencer, the pooling
// unit, the two flatten memories and FC1.
interface flatten_seq_if
    import flatten_seq_pkg::*;
#(
    parameter int AW = flat_aw(DEF_CHANNELS, DEF_PIXELS),
    parameter int CW = flat_cw(DEF_CHANNELS, DEF_PIXELS, DEF_POOL_PAR)
);
    logic          start;
    logic          pool_valid;
    logic          fc_release;
    logic          cap_we;
    logic [CW-1:0] cap_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          flatten_done;
    logic          fc_ready;
    logic          busy;

    // Sequencer side.
    modport slave (
        input  start, pool_valid, fc_release,
        output cap_we, cap_addr, rd_en, rd_addr, wr_en, wr_addr,
               flatten_done, fc_ready, busy
    );

    // Controller / surrounding datapath side.
    modport master (
        output start, pool_valid, fc_release,
        input  cap_we, cap_addr, rd_en, rd_addr, wr_en, wr_addr,
               flatten_done, fc_ready, busy
    );
endinterface

// File: rtl/flatten_addr_gen.sv
// Channel-major read address generator: pixel index inner, channel index
// outer, address = pixel*CHANNELS + channel, with a last-element flag.
module flatten_addr_gen
    import flatten_seq_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int PIXELS   = DEF_PIXELS,
    localparam int CB       = $clog2(CHANNELS),
    localparam int PB       = $clog2(PIXELS),
    localparam int AW       = CB + PB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);
    localparam logic [CB-1:0] C_LAST = CB'(CHANNELS - 1);
    localparam logic [PB-1:0] P_LAST = PB'(PIXELS - 1);

    logic [CB-1:0] r_c;
    logic [PB-1:0] r_p;

    // Both counters wrap at their width, so a finished pass leaves them at 0.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_c <= '0;
            r_p <= '0;
        end else if (i_en) begin
            r_p <= r_p + 1'b1;
            if (r_p == P_LAST) begin
                r_c <= r_c + 1'b1;
            end
        end
    end

    // Power-of-two geometry turns p*CHANNELS + c into a concatenation.
    assign o_addr = {r_p, r_c};
    assign o_last = (r_p == P_LAST) && (r_c == C_LAST);

endmodule

// File: rtl/flatten_seq.sv
// Flatten-stage sequencer: captures pooled words into BRAM1, streams the
// transposing BRAM1 -> BRAM2 copy, then holds the vector for FC1.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start, all enables low
// S_CAPTURE   | writing pooled words to BRAM1 at the capture counter
// S_TRANSPOSE | N channel-major reads, writes trail by one cycle
// S_READY     | BRAM2 holds the flattened vector until FC1 releases it
module flatten_seq
    import flatten_seq_pkg::*;
#(
    parameter int CHANNELS         = DEF_CHANNELS,
    parameter int PIXELS           = DEF_PIXELS,
    parameter int POOL_PARALLELISM = DEF_POOL_PAR
) (
    input  logic          clk,
    input  logic          rst,
    flatten_seq_if.slave  bus
);
    localparam int N  = CHANNELS * PIXELS;
    localparam int NW = N / POOL_PARALLELISM;
    localparam int AW = flat_aw(CHANNELS, PIXELS);
    localparam int CW = flat_cw(CHANNELS, PIXELS, POOL_PARALLELISM);

    localparam logic [CW-1:0] CAP_LAST = CW'(NW - 1);

    flat_state_e   r_state;
    logic [CW-1:0] r_cap_cnt;
    logic          r_rd_en;
    logic [AW-1:0] r_rd_seq;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic          r_wr_last;
    logic          r_done;
    logic          r_fc_ready;
    logic          r_busy;

    logic          w_start_acc;
    logic [AW-1:0] w_rd_addr;
    logic          w_rd_last;

    assign w_start_acc = (r_state == S_IDLE) && bus.start;

    flatten_addr_gen #(
        .CHANNELS (CHANNELS),
        .PIXELS   (PIXELS)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start_acc),
        .i_en   (r_rd_en),
        .o_addr (w_rd_addr),
        .o_last (w_rd_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cap_cnt  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_seq   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_last  <= 1'b0;
            r_done     <= 1'b0;
            r_fc_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // Write side is the read side delayed one cycle to match BRAM latency.
            r_wr_en   <= r_rd_en;
            r_wr_addr <= r_rd_seq;
            r_wr_last <= r_rd_en && w_rd_last;
            r_done    <= 1'b0;
            if (r_rd_en) begin
                r_rd_seq <= r_rd_seq + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_CAPTURE;
                        r_cap_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (bus.pool_valid) begin
                        r_cap_cnt <= r_cap_cnt + 1'b1;
                        if (r_cap_cnt == CAP_LAST) begin
                            r_state <= S_TRANSPOSE;
                            r_rd_en <= 1'b1;
                        end
                    end
                end
                S_TRANSPOSE: begin
                    if (r_rd_en && w_rd_last) begin
                        r_rd_en <= 1'b0;
                    end
                    if (r_wr_last) begin
                        r_state    <= S_READY;
                        r_done     <= 1'b1;
                        r_fc_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.fc_release) begin
                        r_state    <= S_IDLE;
                        r_fc_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture write strobe follows pool_valid in the same cycle.
    assign bus.cap_we       = (r_state == S_CAPTURE) && bus.pool_valid;
    assign bus.cap_addr     = r_cap_cnt;
    assign bus.rd_en        = r_rd_en;
    assign bus.rd_addr      = w_rd_addr;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.flatten_done = r_done;
    assign bus.fc_ready     = r_fc_ready;
    assign bus.busy         = r_busy;

endmodule
